sdram_port_arbiter: RTL and testbench

Parametrised N-port front end for the single-request SDRAM controller. It replaces the fixed two-way address/`in_valid` mux between the flash-load path and the 6502 bus path with a buffered, round-robin arbiter. Each client port (flash loader, CPU bus, PPU bus, debug UART) gets a one-deep request slot and a per-port response strobe. The block sits between the client blocks and `sdram`, driving its `addr`/`rw`/`data_in`/`in_valid` inputs and consuming `busy`/`out_valid`/`data_out`.

---
 rtl/sdram_port_arbiter_if.sv | 32 +++
 rtl/sdram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Client-side request/response bundle plus the sdram controller handshake for sdram_port_arbiter.
// The arbiter takes the slave view and the surrounding clients/controller the master view.
interface sdram_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_rw;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]           rsp_data;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic                            mem_rw;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_in_valid;
  logic                            mem_busy;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            mem_out_valid;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, mem_busy, mem_rdata, mem_out_valid,
    output req_ready, rsp_valid, rsp_data, mem_addr, mem_rw, mem_wdata, mem_in_valid
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, mem_busy, mem_rdata, mem_out_valid,
    input  req_ready, rsp_valid, rsp_data, mem_addr, mem_rw, mem_wdata, mem_in_valid
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// N-port buffered round-robin front end for the single-request sdram controller.
// Define SDRAM_ARB_PORT0_PRIORITY_EN to make port 0 (6502 bus) win whenever it is pending.
module sdram_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  sdram_port_arbiter_if.slave bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]            state;
  logic [NUM_PORTS-1:0]  pending;
  logic [NUM_PORTS-1:0]  slot_rw;
  logic [ADDR_WIDTH-1:0] slot_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] slot_wdata [NUM_PORTS];
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         grant;
  logic [PW-1:0]         winner;
  logic [PW-1:0]         idx_p;
  logic [PW-1:0]         next_ptr;
  logic                  found;
  logic                  done;
  int                    idx;

  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic                  mem_rw_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  mem_in_valid_r;
  logic [NUM_PORTS-1:0]  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;

  // First pending port at or after rr_ptr, wrapping; port 0 may pre-empt the scan.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_p  = '0;
`ifdef SDRAM_ARB_PORT0_PRIORITY_EN
    if (pending[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      idx_p = PW'(idx);
      if (!found && pending[idx_p]) begin
        found  = 1'b1;
        winner = idx_p;
      end
    end
  end

  assign done     = (state == S_WAIT) && (mem_rw_r ? !bus.mem_busy : bus.mem_out_valid);
  assign next_ptr = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      slot_rw <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (bus.req_valid[i] && !pending[i]) begin
          pending[i]    <= 1'b1;
          slot_rw[i]    <= bus.req_rw[i];
          slot_addr[i]  <= bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          slot_wdata[i] <= bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (done && grant == PW'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Busy is only trusted in IDLE and WAIT; the controller raises it a cycle after in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      grant          <= '0;
      mem_addr_r     <= '0;
      mem_rw_r       <= 1'b0;
      mem_wdata_r    <= '0;
      mem_in_valid_r <= 1'b0;
      rsp_valid_r    <= '0;
      rsp_data_r     <= '0;
    end else begin
      rsp_valid_r    <= '0;
      mem_in_valid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found && !bus.mem_busy) begin
            grant          <= winner;
            mem_addr_r     <= slot_addr[winner];
            mem_rw_r       <= slot_rw[winner];
            mem_wdata_r    <= slot_wdata[winner];
            mem_in_valid_r <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (done) begin
            rsp_valid_r[grant] <= 1'b1;
            if (!mem_rw_r) rsp_data_r <= bus.mem_rdata;
`ifdef SDRAM_ARB_PORT0_PRIORITY_EN
            if (grant != '0) rr_ptr <= next_ptr;
`else
            rr_ptr <= next_ptr;
`endif
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = ~pending;
  assign bus.rsp_valid    = rsp_valid_r;
  assign bus.rsp_data     = rsp_data_r;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.mem_rw       = mem_rw_r;
  assign bus.mem_wdata    = mem_wdata_r;
  assign bus.mem_in_valid = mem_in_valid_r;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter (3 ports) with an sdram controller model and a transaction scoreboard.
// Expected grant order follows SDRAM_ARB_PORT0_PRIORITY_EN when it is defined.
module tb_sdram_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 23;
  localparam int DW = 32;

  logic clk = 1'b1;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sdram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // sdram controller model, updated on the falling edge
  logic [DW-1:0] mm_mem [logic [AW-1:0]];
  int            mm_cnt = 0;
  int            mm_fixed_lat = 0;
  logic          mm_rw = 1'b0;
  logic [AW-1:0] mm_addr = '0;
  logic          mm_done = 1'b0;
  logic          force_busy = 1'b0;
  logic          spurious_ov = 1'b0;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {a, 9'h000} ^ 32'h3C3C_A5A5;
  endfunction

  always @(negedge clk) begin
    bus.mem_out_valid = 1'b0;
    mm_done = 1'b0;
    if (rst) begin
      mm_cnt = 0;
      bus.mem_rdata = '0;
    end else if (mm_cnt > 0) begin
      mm_cnt--;
      if (mm_cnt == 0) begin
        mm_done = 1'b1;
        if (!mm_rw) begin
          bus.mem_out_valid = 1'b1;
          bus.mem_rdata = mm_mem.exists(mm_addr) ? mm_mem[mm_addr] : dflt(mm_addr);
        end
      end
    end else if (bus.mem_in_valid) begin
      mm_rw   = bus.mem_rw;
      mm_addr = bus.mem_addr;
      if (mm_rw) mm_mem[mm_addr] = bus.mem_wdata;
      mm_cnt = (mm_fixed_lat > 0) ? mm_fixed_lat : int'($urandom_range(2, 8));
    end
    bus.mem_busy = (mm_cnt > 0) || force_busy;
    if (spurious_ov) bus.mem_out_valid = 1'b1;
  end

  // Transaction-level reference: slots, round-robin pointer, one op in flight
  logic [NP-1:0] m_pend = '0;
  logic          m_rw    [NP];
  logic [AW-1:0] m_addr  [NP];
  logic [DW-1:0] m_wdata [NP];
  logic [DW-1:0] sh_mem  [logic [AW-1:0]];
  int            m_rr = 0;
  int            m_g  = 0;
  bit            m_fly = 1'b0;
  logic [DW-1:0] m_rsp_data = '0;
  logic [NP-1:0] acc_last = '0;
  logic [NP-1:0] rsp_last = '0;
  int            grant_log [$];

  function automatic int pick(input logic [NP-1:0] p, input int rr);
`ifdef SDRAM_ARB_PORT0_PRIORITY_EN
    if (p[0]) return 0;
`endif
    for (int k = 0; k < NP; k++) begin
      if (p[(rr + k) % NP]) return (rr + k) % NP;
    end
    return -1;
  endfunction

  task automatic set_req(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[p] = 1'b1;
    bus.req_rw[p] = rw;
    bus.req_addr[p*AW +: AW] = a;
    bus.req_wdata[p*DW +: DW] = d;
  endtask

  // One clock: score the edge against the reference, then retire accepted requests
  task automatic step();
    logic [NP-1:0] pb;
    logic [NP-1:0] exp_rsp;
    bit            exp_iv;
    int            w;
    @(posedge clk);
    #1;
    pb = m_pend;
    acc_last = '0;
    rsp_last = bus.rsp_valid;
    if (rst) begin
      m_pend = '0;
      m_fly = 1'b0;
      m_rr = 0;
      m_rsp_data = '0;
      return;
    end
    exp_iv = !m_fly && (pb != '0) && !bus.mem_busy;
    exp_rsp = '0;
    if (m_fly && mm_done) exp_rsp[m_g] = 1'b1;
    n_tests++;
    if (bus.mem_in_valid !== exp_iv) begin
      n_fail++;
      $display("[TB] FAIL sb_in_valid: got %0b, expected %0b at %0t", bus.mem_in_valid, exp_iv, $time);
    end
    n_tests++;
    if (bus.rsp_valid !== exp_rsp) begin
      n_fail++;
      $display("[TB] FAIL sb_rsp_valid: got %b, expected %b at %0t", bus.rsp_valid, exp_rsp, $time);
    end
    if (exp_rsp != '0) begin
      if (!m_rw[m_g])
        m_rsp_data = sh_mem.exists(m_addr[m_g]) ? sh_mem[m_addr[m_g]] : dflt(m_addr[m_g]);
      m_pend[m_g] = 1'b0;
`ifdef SDRAM_ARB_PORT0_PRIORITY_EN
      if (m_g != 0) m_rr = (m_g + 1) % NP;
`else
      m_rr = (m_g + 1) % NP;
`endif
      m_fly = 1'b0;
    end
    n_tests++;
    if (bus.rsp_data !== m_rsp_data) begin
      n_fail++;
      $display("[TB] FAIL sb_rsp_data: got %h, expected %h at %0t", bus.rsp_data, m_rsp_data, $time);
    end
    if (exp_iv) begin
      w = pick(pb, m_rr);
      m_g = w;
      m_fly = 1'b1;
      grant_log.push_back(w);
      n_tests++;
      if (bus.mem_addr !== m_addr[w] || bus.mem_rw !== m_rw[w] || bus.mem_wdata !== m_wdata[w]) begin
        n_fail++;
        $display("[TB] FAIL sb_issue: got addr %h rw %0b wdata %h, expected port %0d addr %h rw %0b wdata %h",
                 bus.mem_addr, bus.mem_rw, bus.mem_wdata, w, m_addr[w], m_rw[w], m_wdata[w]);
      end
      if (m_rw[w]) sh_mem[m_addr[w]] = m_wdata[w];
    end
    acc_last = bus.req_valid & ~pb;
    for (int i = 0; i < NP; i++) begin
      if (acc_last[i]) begin
        m_rw[i]    = bus.req_rw[i];
        m_addr[i]  = bus.req_addr[i*AW +: AW];
        m_wdata[i] = bus.req_wdata[i*DW +: DW];
      end
    end
    m_pend = m_pend | acc_last;
    n_tests++;
    if (bus.req_ready !== ~m_pend) begin
      n_fail++;
      $display("[TB] FAIL sb_req_ready: got %b, expected %b at %0t", bus.req_ready, ~m_pend, $time);
    end
    bus.req_valid = bus.req_valid & ~acc_last;
  endtask

  task automatic drain(output bit ok);
    int c = 0;
    while ((m_pend != '0 || m_fly || bus.req_valid != '0) && c < 400) begin
      step();
      c++;
    end
    ok = (c < 400);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (bus.req_ready !== {NP{1'b1}}) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b, expected 111", bus.req_ready); end
    n_tests++;
    if (bus.rsp_valid !== '0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b, expected 0", bus.rsp_valid); end
    n_tests++;
    if (bus.rsp_data !== '0) begin n_fail++; $display("[TB] FAIL reset_rsp_data: got %h, expected 0", bus.rsp_data); end
    n_tests++;
    if (bus.mem_addr !== '0 || bus.mem_rw !== 1'b0 || bus.mem_wdata !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mem_bus: got addr %h rw %0b wdata %h, expected all 0", bus.mem_addr, bus.mem_rw, bus.mem_wdata);
    end
    n_tests++;
    if (bus.mem_in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_valid: got %0b, expected 0", bus.mem_in_valid); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    int pulses1 = 0;
    int pulses0 = 0;
    mm_fixed_lat = 6;
    mm_mem[23'h000123] = 32'hDEADBEEF;
    sh_mem[23'h000123] = 32'hDEADBEEF;
    set_req(1, 1'b0, 23'h000123, 32'h0);
    step();
    step();
    n_tests++;
    if (bus.mem_in_valid !== 1'b1 || bus.mem_addr !== 23'h000123 || bus.mem_rw !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_issue: got iv %0b addr %h rw %0b, expected iv 1 addr 000123 rw 0", bus.mem_in_valid, bus.mem_addr, bus.mem_rw);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.rsp_valid[0]) pulses0++;
      if (bus.rsp_valid[1]) begin
        pulses1++;
        n_tests++;
        if (bus.rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL read_data: got %h, expected deadbeef", bus.rsp_data); end
      end
    end
    n_tests++;
    if (pulses1 != 1) begin n_fail++; $display("[TB] FAIL read_pulses: got %0d, expected 1", pulses1); end
    n_tests++;
    if (pulses0 != 0) begin n_fail++; $display("[TB] FAIL read_port0_quiet: got %0d pulses, expected 0", pulses0); end
    mm_fixed_lat = 0;
  endtask

  task automatic test_write();
    bit seen = 1'b0;
    logic prev_busy;
    set_req(0, 1'b1, 23'h7FFFFF, 32'h0000_00A5);
    step();
    step();
    n_tests++;
    if (bus.mem_in_valid !== 1'b1 || bus.mem_addr !== 23'h7FFFFF || bus.mem_rw !== 1'b1 || bus.mem_wdata !== 32'hA5) begin
      n_fail++;
      $display("[TB] FAIL write_issue: got iv %0b addr %h rw %0b wdata %h, expected 1 7fffff 1 000000a5",
               bus.mem_in_valid, bus.mem_addr, bus.mem_rw, bus.mem_wdata);
    end
    prev_busy = bus.mem_busy;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (bus.rsp_valid[0]) begin
        seen = 1'b1;
        n_tests++;
        if (prev_busy !== 1'b1 || bus.mem_busy !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL write_rsp_timing: got busy %0b then %0b, expected 1 then 0", prev_busy, bus.mem_busy);
        end
        n_tests++;
        if (bus.req_ready[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL write_ready_after: got %0b, expected 1", bus.req_ready[0]); end
      end
      prev_busy = bus.mem_busy;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("[TB] FAIL write_rsp_timeout: got no rsp_valid[0], expected one within 20 cycles"); end
  endtask

  task automatic test_round_robin();
    int base;
    int c = 0;
    bit ok;
`ifdef SDRAM_ARB_PORT0_PRIORITY_EN
    int exp_order [6] = '{0, 1, 0, 2, 0, 1};
`else
    int exp_order [6] = '{0, 1, 2, 0, 1, 2};
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) set_req(i, 1'b0, AW'(23'h000400 + i), 32'h0);
    base = grant_log.size();
    while (grant_log.size() < base + 6 && c < 300) begin
      step();
      for (int i = 0; i < NP; i++)
        if (rsp_last[i]) set_req(i, 1'b0, AW'($urandom_range(0, 63)), 32'h0);
      c++;
    end
    bus.req_valid = '0;
    n_tests++;
    if (grant_log.size() < base + 6) begin
      n_fail++;
      $display("[TB] FAIL rr_timeout: got %0d grants, expected 6", grant_log.size() - base);
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (grant_log[base + k] != exp_order[k]) begin
          n_fail++;
          $display("[TB] FAIL rr_order[%0d]: got port %0d, expected port %0d", k, grant_log[base + k], exp_order[k]);
        end
      end
    end
    drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("[TB] FAIL rr_drain: got work outstanding, expected idle"); end
  endtask

  task automatic test_busy_gating();
    bit ok;
    force_busy = 1'b1;
    step();
    set_req(2, 1'b0, 23'h001234, 32'h0);
    for (int c = 0; c < 20; c++) begin
      step();
      n_tests++;
      if (bus.mem_in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_hold[%0d]: got in_valid 1, expected 0", c); end
    end
    force_busy = 1'b0;
    step();
    n_tests++;
    if (bus.mem_in_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_release: got in_valid %0b, expected 1", bus.mem_in_valid); end
    drain(ok);
    step();
    spurious_ov = 1'b1;
    step();
    spurious_ov = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_tests++;
      if (bus.rsp_valid !== '0) begin n_fail++; $display("[TB] FAIL spurious_idle: got rsp %b, expected 0", bus.rsp_valid); end
    end
  endtask

  task automatic test_reset_mid_read();
    mm_fixed_lat = 10;
    set_req(1, 1'b0, 23'h0ABCDE, 32'h0);
    for (int c = 0; c < 4; c++) step();
    rst = 1'b1;
    step();
    n_tests++;
    if (bus.req_ready !== {NP{1'b1}} || bus.rsp_valid !== '0 || bus.rsp_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_client: got ready %b rsp %b data %h, expected 111 000 0", bus.req_ready, bus.rsp_valid, bus.rsp_data);
    end
    n_tests++;
    if (bus.mem_addr !== '0 || bus.mem_rw !== 1'b0 || bus.mem_wdata !== '0 || bus.mem_in_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_mem: got addr %h rw %0b wdata %h iv %0b, expected all 0",
               bus.mem_addr, bus.mem_rw, bus.mem_wdata, bus.mem_in_valid);
    end
    rst = 1'b0;
    spurious_ov = 1'b1;
    step();
    spurious_ov = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (bus.rsp_valid !== '0) begin n_fail++; $display("[TB] FAIL midreset_late: got rsp %b, expected 0", bus.rsp_valid); end
    end
    mm_fixed_lat = 0;
  endtask

  task automatic test_random();
    bit ok;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NP; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom());
      step();
    end
    drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("[TB] FAIL random_drain: got work outstanding, expected idle"); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_busy_gating();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
